// File: rtl/matmul_pkg.sv
// Shared state encoding, element-slice macro and float constants for matmul_seq.
// The element-slice macro is global once this file has been compiled.
`ifndef MATMUL_PKG_SV
`define MATMUL_PKG_SV

// Row-major element slice: element idx of width w, element 0 at the LSB.
`define MATMUL_ELEM(vec, idx, w) vec[(w)*(idx) +: (w)]

package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_ADD,
        S_STORE,
        S_DONE
    } state_e;

    localparam logic [63:0] FP_POS_ZERO = 64'h0;

    function automatic int unsigned fp_exp_w(input int unsigned s);
        if (s == 16) return 5;
        if (s == 64) return 11;
        return 8;
    endfunction

endpackage

`endif

// File: rtl/add_float.sv
// Float adder, start/done handshake, result and flags valid with done one cycle later.
// Subnormals flush to zero; alignment truncates; +0 + -0 gives +0.
module add_float
    import matmul_pkg::*;
#(
    parameter int unsigned S = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    output logic [S-1:0] y,
    output logic         done,
    output logic         nan,
    output logic         ovf
);
    localparam int unsigned E = fp_exp_w(S);
    localparam int unsigned M = S - 1 - E;
    localparam int EMAX = (1 << E) - 1;
    localparam logic [S-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};

    logic [S-1:0]   x, z, y_d;
    logic [M+3:0]   mx, mz, mz_sh;
    logic [M+4:0]   sum;
    logic [E-1:0]   d;
    logic           x_nan, x_inf, z_inf, nan_d, ovf_d;
    logic           unused_bits;
    int             ex;

    assign unused_bits = ^sum[2:0];

    always_comb begin
        // x always carries the larger magnitude, so specials and the result sign follow x.
        if (a[S-2:0] >= b[S-2:0]) begin
            x = a;
            z = b;
        end else begin
            x = b;
            z = a;
        end
        x_nan = (&x[S-2 -: E]) && (|x[M-1:0]);
        x_inf = (&x[S-2 -: E]) && !(|x[M-1:0]);
        z_inf = (&z[S-2 -: E]) && !(|z[M-1:0]);
        mx    = {1'b1, x[M-1:0], 3'b000};
        mz    = {1'b1, z[M-1:0], 3'b000};
        d     = x[S-2 -: E] - z[S-2 -: E];
        mz_sh = (int'(d) > int'(M + 3)) ? '0 : (mz >> d);
        ex    = int'(x[S-2 -: E]);
        if (x[S-1] == z[S-1]) sum = {1'b0, mx} + {1'b0, mz_sh};
        else                  sum = {1'b0, mx} - {1'b0, mz_sh};
        if (sum[M+4]) begin
            sum = sum >> 1;
            ex  = ex + 1;
        end
        for (int sh = 0; sh < int'(M + 4); sh++) begin
            if (!sum[M+3] && (sum != '0)) begin
                sum = sum << 1;
                ex  = ex - 1;
            end
        end
        nan_d = 1'b0;
        ovf_d = 1'b0;
        y_d   = {x[S-1], ex[E-1:0], sum[M+2:3]};
        if (x_nan || (x_inf && z_inf && (x[S-1] != z[S-1]))) begin
            y_d   = QNAN;
            nan_d = 1'b1;
        end else if (x_inf) begin
            y_d = x;
        end else if (x[S-2 -: E] == '0) begin
            y_d = {x[S-1] & z[S-1], {(S - 1){1'b0}}};
        end else if (z[S-2 -: E] == '0) begin
            y_d = x;
        end else if (sum == '0) begin
            y_d = '0;
        end else if (ex >= EMAX) begin
            y_d   = {x[S-1], {E{1'b1}}, {M{1'b0}}};
            ovf_d = 1'b1;
        end else if (ex <= 0) begin
            y_d   = {x[S-1], {(S - 1){1'b0}}};
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y    <= '0;
            done <= 1'b0;
            nan  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                y   <= y_d;
                nan <= nan_d;
                ovf <= ovf_d;
            end
        end
    end

endmodule

// File: rtl/fp_mac_lane.sv
// One multiply-accumulate lane: mul_float feeding add_float, with the running accumulator.
module fp_mac_lane #(
    parameter int unsigned S = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mul_go,
    input  logic         add_go,
    input  logic         ld_init,
    input  logic [S-1:0] init_val,
    input  logic [S-1:0] a_op,
    input  logic [S-1:0] b_op,
    output logic         mul_done,
    output logic         add_done,
    output logic [S-1:0] acc,
    output logic         nan,
    output logic         ovf
);
    logic [S-1:0] prod, sum, acc_q;
    logic         mul_nan, mul_ovf, add_nan, add_ovf;

    mul_float #(.S(S)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_go),
        .a     (a_op),
        .b     (b_op),
        .y     (prod),
        .done  (mul_done),
        .nan   (mul_nan),
        .ovf   (mul_ovf)
    );

    add_float #(.S(S)) u_add (
        .clk   (clk),
        .rst_n (rst_n),
        .start (add_go),
        .a     (acc_q),
        .b     (prod),
        .y     (sum),
        .done  (add_done),
        .nan   (add_nan),
        .ovf   (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc_q <= '0;
        else if (ld_init)  acc_q <= init_val;
        else if (add_done) acc_q <= sum;
    end

    assign acc = acc_q;
    assign nan = (mul_done && mul_nan) || (add_done && add_nan);
    assign ovf = (mul_done && mul_ovf) || (add_done && add_ovf);

endmodule

// File: rtl/mul_float.sv
// Float multiplier, start/done handshake, result and flags valid with done one cycle later.
// Subnormals flush to zero; mantissa truncates; NaN results are the canonical quiet NaN.
module mul_float
    import matmul_pkg::*;
#(
    parameter int unsigned S = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    output logic [S-1:0] y,
    output logic         done,
    output logic         nan,
    output logic         ovf
);
    localparam int unsigned E = fp_exp_w(S);
    localparam int unsigned M = S - 1 - E;
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int EMAX = (1 << E) - 1;
    localparam logic [S-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};

    logic [2*M+1:0] prod;
    logic [M-1:0]   man;
    logic [S-1:0]   y_d;
    logic           sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nan_d, ovf_d;
    logic           unused_bits;
    int             ex;

    assign unused_bits = ^prod[M-1:0];

    always_comb begin
        sign   = a[S-1] ^ b[S-1];
        a_zero = a[S-2 -: E] == '0;
        b_zero = b[S-2 -: E] == '0;
        a_inf  = (&a[S-2 -: E]) && !(|a[M-1:0]);
        b_inf  = (&b[S-2 -: E]) && !(|b[M-1:0]);
        a_nan  = (&a[S-2 -: E]) && (|a[M-1:0]);
        b_nan  = (&b[S-2 -: E]) && (|b[M-1:0]);
        prod   = {1'b1, a[M-1:0]} * {1'b1, b[M-1:0]};
        ex     = int'(a[S-2 -: E]) + int'(b[S-2 -: E]) - BIAS;
        if (prod[2*M+1]) begin
            man = prod[2*M -: M];
            ex  = ex + 1;
        end else begin
            man = prod[2*M-1 -: M];
        end
        nan_d = 1'b0;
        ovf_d = 1'b0;
        y_d   = {sign, ex[E-1:0], man};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y_d   = QNAN;
            nan_d = 1'b1;
        end else if (a_inf || b_inf) begin
            y_d = {sign, {E{1'b1}}, {M{1'b0}}};
        end else if (a_zero || b_zero) begin
            y_d = {sign, {(S - 1){1'b0}}};
        end else if (ex >= EMAX) begin
            y_d   = {sign, {E{1'b1}}, {M{1'b0}}};
            ovf_d = 1'b1;
        end else if (ex <= 0) begin
            y_d   = {sign, {(S - 1){1'b0}}};
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y    <= '0;
            done <= 1'b0;
            nan  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                y   <= y_d;
                nan <= nan_d;
                ovf <= ovf_d;
            end
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Time-multiplexed float matrix multiplier O = A*B over P shared MAC lanes.
// Define MATMUL_SEQ_BIAS_EN to add a bias input that seeds the accumulators (O = A*B + Bias).
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int unsigned S = 32,
    parameter int unsigned H = 2,
    parameter int unsigned W = 2,
    parameter int unsigned C = 2,
    parameter int unsigned P = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [S*H*C-1:0] a,
    input  logic [S*C*W-1:0] b,
`ifdef MATMUL_SEQ_BIAS_EN
    input  logic [S*H*W-1:0] bias,
`endif
    output logic [S*H*W-1:0] o,
    output logic             busy,
    output logic             done,
    output logic             nan_flag,
    output logic             ovf_flag
);
    localparam int unsigned N  = H * W;
    localparam int unsigned NP = (N + P - 1) / P;
    localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int unsigned KW = (C > 1) ? $clog2(C) : 1;

    state_e           state_q, state_d;
    logic [PW-1:0]    p_q;
    logic [KW-1:0]    k_q;
    logic             issued_q, nan_q, ovf_q;
    logic [P-1:0]     seen_q;
    logic [S*H*C-1:0] a_q;
    logic [S*C*W-1:0] b_q;
    logic [S*N-1:0]   o_q;
`ifdef MATMUL_SEQ_BIAS_EN
    logic [S*N-1:0]   bias_q;
`endif
    logic [P-1:0]     active, mul_go, add_go, mul_done, add_done, lane_nan, lane_ovf;
    logic [S-1:0]     a_sel [P];
    logic [S-1:0]     b_sel [P];
    logic [S-1:0]     init_sel [P];
    logic [S-1:0]     acc [P];
    logic [31:0]      lane_n [P];
    logic             accept, phase_done, last_k, last_p, ld_init;

    assign accept  = (state_q == S_IDLE) && start;
    assign last_k  = k_q == KW'(C - 1);
    assign last_p  = p_q == PW'(NP - 1);
    assign ld_init = state_q == S_LOAD;

    // Output index n = p*P + lane; lanes past the last element are masked.
    always_comb begin
        int unsigned n, i, j;
        n = 0;
        i = 0;
        j = 0;
        for (int l = 0; l < int'(P); l++) begin
            lane_n[l] = 32'(p_q) * P + 32'(l);
            active[l] = lane_n[l] < N;
            n         = active[l] ? lane_n[l] : 0;
            i         = n / W;
            j         = n % W;
            a_sel[l]  = `MATMUL_ELEM(a_q, i * C + 32'(k_q), S);
            b_sel[l]  = `MATMUL_ELEM(b_q, 32'(k_q) * W + j, S);
`ifdef MATMUL_SEQ_BIAS_EN
            init_sel[l] = `MATMUL_ELEM(bias_q, n, S);
`else
            init_sel[l] = FP_POS_ZERO[S-1:0];
`endif
        end
    end

    always_comb begin
        mul_go = '0;
        add_go = '0;
        if (state_q == S_MUL && !issued_q) mul_go = active;
        if (state_q == S_ADD && !issued_q) add_go = active;
    end

    assign phase_done = issued_q && (&(seen_q | mul_done | add_done | ~active));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_MUL;
            S_MUL:   if (phase_done) state_d = S_ADD;
            S_ADD:   if (phase_done) state_d = last_k ? S_STORE : S_MUL;
            S_STORE: state_d = last_p ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            k_q      <= '0;
            issued_q <= 1'b0;
            seen_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            o_q      <= '0;
            nan_q    <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef MATMUL_SEQ_BIAS_EN
            bias_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                p_q   <= '0;
                nan_q <= 1'b0;
                ovf_q <= 1'b0;
`ifdef MATMUL_SEQ_BIAS_EN
                bias_q <= bias;
`endif
            end else begin
                nan_q <= nan_q | (|lane_nan);
                ovf_q <= ovf_q | (|lane_ovf);
            end
            if (state_q == S_LOAD) k_q <= '0;
            if (state_q == S_ADD && phase_done && !last_k) k_q <= k_q + 1'b1;
            if (state_q == S_STORE && !last_p) p_q <= p_q + 1'b1;
            if ((|mul_go) || (|add_go)) issued_q <= 1'b1;
            if (phase_done) begin
                issued_q <= 1'b0;
                seen_q   <= '0;
            end else begin
                seen_q <= seen_q | mul_done | add_done;
            end
            if (state_q == S_STORE) begin
                for (int l = 0; l < int'(P); l++) begin
                    if (active[l]) o_q[S*lane_n[l] +: S] <= acc[l];
                end
            end
        end
    end

    for (genvar l = 0; l < int'(P); l++) begin : g_lane
        fp_mac_lane #(.S(S)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .mul_go   (mul_go[l]),
            .add_go   (add_go[l]),
            .ld_init  (ld_init),
            .init_val (init_sel[l]),
            .a_op     (a_sel[l]),
            .b_op     (b_sel[l]),
            .mul_done (mul_done[l]),
            .add_done (add_done[l]),
            .acc      (acc[l]),
            .nan      (lane_nan[l]),
            .ovf      (lane_ovf[l])
        );
    end

    assign o        = o_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = state_q == S_DONE;
    assign nan_flag = nan_q;
    assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: three instances (P=1, P=4, P=3) share one stimulus stream.
module tb_matmul_seq;
    localparam int LM = 1;
    localparam int LA = 1;
    localparam logic [127:0] A_BASE = 128'h40800000_40400000_40000000_3F800000;
    localparam logic [127:0] A_NAN  = 128'h40800000_40400000_40000000_7FC00000;
    localparam logic [127:0] A_TWO  = 128'h40000000_40000000_40000000_40000000;
    localparam logic [127:0] E_BASE = 128'h41B00000_41700000_41200000_40E00000;
    localparam logic [127:0] E_NAN  = 128'h41B00000_41700000_7FC00000_7FC00000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] a = A_BASE;
    logic [127:0] b = A_BASE;
    logic [127:0] o1, o4, o3;
    logic         busy1, busy4, busy3, done1, done4, done3;
    logic         nan1, nan4, nan3, ovf1, ovf4, ovf3;
`ifdef MATMUL_SEQ_BIAS_EN
    logic [127:0] bias = '0;
`endif

    int cyc = 0;
    int start_cyc = 0;
    int dc1 = 0, dc4 = 0, dc3 = 0;
    int dcy1 = 0, dcy4 = 0, dcy3 = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done1) begin dc1 <= dc1 + 1; dcy1 <= cyc; end
        if (done4) begin dc4 <= dc4 + 1; dcy4 <= cyc; end
        if (done3) begin dc3 <= dc3 + 1; dcy3 <= cyc; end
    end

    matmul_seq #(.S(32), .H(2), .W(2), .C(2), .P(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef MATMUL_SEQ_BIAS_EN
        .bias(bias),
`endif
        .o(o1), .busy(busy1), .done(done1), .nan_flag(nan1), .ovf_flag(ovf1)
    );

    matmul_seq #(.S(32), .H(2), .W(2), .C(2), .P(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef MATMUL_SEQ_BIAS_EN
        .bias(bias),
`endif
        .o(o4), .busy(busy4), .done(done4), .nan_flag(nan4), .ovf_flag(ovf4)
    );

    matmul_seq #(.S(32), .H(2), .W(2), .C(2), .P(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef MATMUL_SEQ_BIAS_EN
        .bias(bias),
`endif
        .o(o3), .busy(busy3), .done(done3), .nan_flag(nan3), .ovf_flag(ovf3)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Inclusive count from the cycle start is driven to the cycle done is high.
    function automatic int lat_exp(input int p);
        int np;
        np = (4 + p - 1) / p;
        return np * (2 + 2 * (LM + LA + 2)) + 2;
    endfunction

    // Called at a negedge; issues one start and waits for every instance to finish.
    task automatic run_op(input string tag, input logic [127:0] want);
        int b1, b4, b3;
        b1 = dc1;
        b4 = dc4;
        b3 = dc3;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (dc1 != b1 && dc4 != b4 && dc3 != b3) break;
            @(negedge clk);
        end
        @(negedge clk);
        check_eq({tag, "_ndone_p1"}, dc1 - b1, 1);
        check_eq({tag, "_ndone_p4"}, dc4 - b4, 1);
        check_eq({tag, "_ndone_p3"}, dc3 - b3, 1);
        check_eq({tag, "_lat_p1"}, dcy1 - start_cyc + 1, lat_exp(1));
        check_eq({tag, "_lat_p4"}, dcy4 - start_cyc + 1, lat_exp(4));
        check_eq({tag, "_lat_p3"}, dcy3 - start_cyc + 1, lat_exp(3));
        check_eq({tag, "_o_p1"}, o1, want);
        check_eq({tag, "_o_p4"}, o4, want);
        check_eq({tag, "_o_p3"}, o3, want);
        check_eq({tag, "_busy"}, {busy1, busy4, busy3}, 3'b000);
    endtask

    initial begin
        int b1;
        repeat (3) @(negedge clk);
        check_eq("rst_o", o1, '0);
        check_eq("rst_busy", {busy1, busy4, busy3}, 3'b000);
        check_eq("rst_done", {done1, done4, done3}, 3'b000);
        check_eq("rst_flags", {nan1, ovf1, nan3, ovf3}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("base", E_BASE);
        check_eq("base_flags", {nan1, ovf1, nan4, ovf4, nan3, ovf3}, 6'b0);

        a = A_NAN;
        run_op("nan", E_NAN);
        check_eq("nan_flag", {nan1, nan4, nan3}, 3'b111);
        check_eq("nan_ovf", {ovf1, ovf4, ovf3}, 3'b000);

        // Next accepted start clears the sticky flag; o holds the old result meanwhile.
        a = A_BASE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("clr_nan", {nan1, nan4, nan3}, 3'b000);
        check_eq("clr_busy", {busy1, busy4, busy3}, 3'b111);
        check_eq("hold_o_p1", o1, E_NAN);
        repeat (60) @(negedge clk);
        check_eq("clr_o_p1", o1, E_BASE);

        // Starts during the run and on the done cycle must be ignored.
        b1 = dc1;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        a = A_TWO;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("ign_busy_mid", busy1, 1'b1);
        for (int t = 0; t < 100; t++) begin
            if (done1) break;
            @(negedge clk);
        end
        check_eq("ign_done_seen", done1, 1'b1);
        check_eq("ign_busy_at_done", busy1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("ign_busy_after", busy1, 1'b0);
        check_eq("ign_done_after", done1, 1'b0);
        repeat (60) @(negedge clk);
        check_eq("ign_ndone", dc1 - b1, 1);
        check_eq("ign_lat", dcy1 - start_cyc + 1, lat_exp(1));
        check_eq("ign_o", o1, E_BASE);

        // Reset asserted while the lanes are in ADD aborts without a done pulse.
        a = A_BASE;
        b1 = dc1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_o_p1", o1, '0);
        check_eq("abort_o_p4", o4, '0);
        check_eq("abort_busy", {busy1, busy4, busy3}, 3'b000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("abort_ndone", dc1 - b1, 0);
        run_op("after_abort", E_BASE);

`ifdef MATMUL_SEQ_BIAS_EN
        bias = {4{32'h3F800000}};
        run_op("bias", 128'h41B80000_41800000_41300000_41000000);
        bias = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
